// File: rtl/irda_tx_pkg.sv
// Shared types and constants for the NEC infrared transmitter: FSM states,
// register map, and the fixed phase lengths of an NEC frame in units.
package irda_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_PEND    = 1;
  localparam int STAT_IRQ     = 2;
  localparam int STAT_OVERRUN = 3;

  localparam logic [6:0] LEAD_MARK_UNITS  = 7'd16;
  localparam logic [6:0] LEAD_SPACE_UNITS = 7'd8;
  localparam logic [6:0] BIT_MARK_UNITS   = 7'd1;
  localparam logic [6:0] ZERO_SPACE_UNITS = 7'd1;
  localparam logic [6:0] ONE_SPACE_UNITS  = 7'd3;
  localparam logic [6:0] STOP_MARK_UNITS  = 7'd1;

  function automatic logic is_mark(input state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

  // Length in units of the phase the FSM is currently in.
  function automatic logic [6:0] phase_units(input state_t s, input logic bit_val,
                                             input logic [6:0] gap_units);
    logic [6:0] units;
    case (s)
      ST_LEAD_MARK:  units = LEAD_MARK_UNITS;
      ST_LEAD_SPACE: units = LEAD_SPACE_UNITS;
      ST_BIT_MARK:   units = BIT_MARK_UNITS;
      ST_BIT_SPACE:  units = bit_val ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
      ST_STOP_MARK:  units = STOP_MARK_UNITS;
      ST_GAP:        units = gap_units;
      default:       units = 7'd1;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/irda_carrier_gen.sv
// Carrier generator: a free-running divider that is held at phase 0 while
// disabled and restarted at mark entry, so every mark opens with a high phase.
module irda_carrier_gen #(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_carrier
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CARRIER_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_carrier;

  // Next divider phase; inputs describe the cycle being entered.
  always_comb begin
    w_cnt_next = '0;
    if (!i_enable || i_restart) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // Divider and registered carrier level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_carrier <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_carrier <= i_enable && ({{(32-CW){1'b0}}, w_cnt_next} < 32'(CARRIER_HIGH));
    end
  end

  assign o_carrier = r_carrier;

endmodule

// File: rtl/irda_nec_transmit.sv
// Avalon-MM NEC infrared transmitter: sends a 32-bit word LSB first as an NEC
// frame with a one-deep pending buffer and a sticky end-of-frame interrupt.
module irda_nec_transmit
  import irda_tx_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int GAP_UNITS    = 72
) (
  input  logic        clk,
  input  logic        reset,
  output logic        irq,
  input  logic        s_cs_n,
  input  logic        s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        ir_tx,
  output logic        ir_env
);

  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [6:0] GAP_U = 7'(GAP_UNITS);

  state_t r_state;
  state_t w_state_next;

  logic [UNIT_W-1:0] r_unit_cnt;
  logic [6:0]        r_phase_cnt;
  logic [4:0]        r_bit_idx;
  logic [31:0]       r_data;
  logic [31:0]       r_pending;
  logic              r_pend_full;
  logic              r_overrun;
  logic              r_irq;
  logic              r_ir_env;

  logic        w_data_wr;
  logic        w_stat_wr;
  logic        w_busy;
  logic        w_cur_bit;
  logic [6:0]  w_units;
  logic        w_unit_end;
  logic        w_phase_end;
  logic        w_done;
  logic        w_load;
  logic [31:0] w_load_word;
  logic        w_pend_take;
  logic        w_pend_store;
  logic        w_overrun_set;
  logic        w_mark_next;
  logic        w_mark_entry;
  logic        w_carrier;

  assign w_data_wr   = !s_cs_n && s_write && (s_address == ADDR_DATA);
  assign w_stat_wr   = !s_cs_n && s_write && (s_address == ADDR_STATUS);
  assign w_busy      = (r_state != ST_IDLE);
  assign w_cur_bit   = r_data[r_bit_idx];
  assign w_units     = phase_units(r_state, w_cur_bit, GAP_U);
  assign w_unit_end  = (r_unit_cnt == UNIT_LAST);
  assign w_phase_end = w_unit_end && (r_phase_cnt == (w_units - 7'd1));
  assign w_done      = (r_state == ST_GAP) && w_phase_end;

  // At frame end the pending word moves out before a same-cycle write lands in
  // pending; with pending empty such a write starts the next frame directly.
  assign w_load        = ((r_state == ST_IDLE) && w_data_wr) || (w_done && (r_pend_full || w_data_wr));
  assign w_load_word   = (w_done && r_pend_full) ? r_pending : s_writedata;
  assign w_pend_take   = w_done && r_pend_full;
  assign w_pend_store  = w_data_wr && w_busy && (w_pend_take || (!r_pend_full && !w_done));
  assign w_overrun_set = w_data_wr && w_busy && r_pend_full && !w_done;

  assign w_mark_next  = is_mark(w_state_next);
  assign w_mark_entry = w_mark_next && !is_mark(r_state);

  // Next-state logic for the frame sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_data_wr) w_state_next = ST_LEAD_MARK;
        else           w_state_next = ST_IDLE;
      end
      ST_LEAD_MARK: begin
        if (w_phase_end) w_state_next = ST_LEAD_SPACE;
        else             w_state_next = ST_LEAD_MARK;
      end
      ST_LEAD_SPACE: begin
        if (w_phase_end) w_state_next = ST_BIT_MARK;
        else             w_state_next = ST_LEAD_SPACE;
      end
      ST_BIT_MARK: begin
        if (w_phase_end) w_state_next = ST_BIT_SPACE;
        else             w_state_next = ST_BIT_MARK;
      end
      ST_BIT_SPACE: begin
        if (w_phase_end) begin
          if (r_bit_idx == 5'd31) w_state_next = ST_STOP_MARK;
          else                    w_state_next = ST_BIT_MARK;
        end else begin
          w_state_next = ST_BIT_SPACE;
        end
      end
      ST_STOP_MARK: begin
        if (w_phase_end) w_state_next = ST_GAP;
        else             w_state_next = ST_STOP_MARK;
      end
      ST_GAP: begin
        if (w_done) begin
          if (r_pend_full || w_data_wr) w_state_next = ST_LEAD_MARK;
          else                          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_GAP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Unit, phase and bit counters; all restart together at a phase boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_unit_cnt  <= '0;
      r_phase_cnt <= 7'd0;
      r_bit_idx   <= 5'd0;
    end else begin
      if ((r_state == ST_IDLE) || w_unit_end) r_unit_cnt <= '0;
      else                                    r_unit_cnt <= r_unit_cnt + UNIT_W'(1);

      if ((r_state == ST_IDLE) || w_phase_end) r_phase_cnt <= 7'd0;
      else if (w_unit_end)                     r_phase_cnt <= r_phase_cnt + 7'd1;
      else                                     r_phase_cnt <= r_phase_cnt;

      if (w_load)                                         r_bit_idx <= 5'd0;
      else if ((r_state == ST_BIT_SPACE) && w_phase_end) r_bit_idx <= r_bit_idx + 5'd1;
      else                                                r_bit_idx <= r_bit_idx;
    end
  end

  // Transmit word and one-deep pending buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= 32'd0;
      r_pending   <= 32'd0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_load) r_data <= w_load_word;
      else        r_data <= r_data;

      if (w_pend_store) r_pending <= s_writedata;
      else              r_pending <= r_pending;

      if (w_pend_store)     r_pend_full <= 1'b1;
      else if (w_pend_take) r_pend_full <= 1'b0;
      else                  r_pend_full <= r_pend_full;
    end
  end

  // Sticky flags: setting takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_done)                                       r_irq <= 1'b1;
      else if (w_stat_wr && s_writedata[STAT_IRQ])      r_irq <= 1'b0;
      else                                              r_irq <= r_irq;

      if (w_overrun_set)                                r_overrun <= 1'b1;
      else if (w_stat_wr && s_writedata[STAT_OVERRUN])  r_overrun <= 1'b0;
      else                                              r_overrun <= r_overrun;
    end
  end

  // Envelope tracks the state being entered so it is aligned with the FSM.
  always_ff @(posedge clk) begin
    if (reset) r_ir_env <= 1'b0;
    else       r_ir_env <= w_mark_next;
  end

  irda_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HIGH(CARRIER_HIGH)
  ) u_carrier (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_mark_next),
    .i_restart(w_mark_entry),
    .o_carrier(w_carrier)
  );

  // Zero-wait-state read mux.
  always_comb begin
    s_readdata = 32'd0;
    if (!s_cs_n && s_read) begin
      if (s_address == ADDR_STATUS) begin
        s_readdata[STAT_BUSY]    = w_busy;
        s_readdata[STAT_PEND]    = r_pend_full;
        s_readdata[STAT_IRQ]     = r_irq;
        s_readdata[STAT_OVERRUN] = r_overrun;
      end else begin
        s_readdata = r_data;
      end
    end else begin
      s_readdata = 32'd0;
    end
  end

  assign irq    = r_irq;
  assign ir_env = r_ir_env;
  assign ir_tx  = r_ir_env & w_carrier;

endmodule

// File: tb/tb_irda_nec_transmit.sv
// Bench for irda_nec_transmit: directed bus stimulus queues expected frames,
// an IR receive monitor decodes ir_env and checks against the queue.
module tb_irda_nec_transmit;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic        s_cs_n;
  logic        s_address;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        ir_tx;
  logic        ir_env;

  typedef struct packed {
    logic [31:0] word;
    logic        b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b1;

  irda_nec_transmit #(
    .UNIT_CYCLES (10),
    .CARRIER_DIV (4),
    .CARRIER_HIGH(1),
    .GAP_UNITS   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .s_cs_n     (s_cs_n),
    .s_address  (s_address),
    .s_read     (s_read),
    .s_readdata (s_readdata),
    .s_write    (s_write),
    .s_writedata(s_writedata),
    .ir_tx      (ir_tx),
    .ir_env     (ir_env)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] word, input logic b2b);
    exp_t e;
    e.word = word;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  // Write sampled at the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic addr, input logic [31:0] data);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = addr; s_writedata = data;
    @(posedge clk); #1;
    s_cs_n = 1'b1; s_write = 1'b0; s_writedata = 32'd0;
  endtask

  task automatic read_reg(input logic addr, output logic [31:0] v);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = addr;
    #1;
    v = s_readdata;
    s_read = 1'b0; s_cs_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count busy cycles (starting at cycle 'start'), note first cycle irq is seen,
  // optionally clearing irq that same cycle.
  task automatic poll_busy(input int start, input bit clear_mid, output int busy, output int irq_first);
    logic [31:0] st;
    st = 32'd1;
    busy = start - 1;
    irq_first = 0;
    s_cs_n = 1'b0; s_address = 1'b1; s_read = 1'b1; s_write = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      #1;
      st = s_readdata;
      if (!st[0]) break;
      busy++;
      if (st[2] && (irq_first == 0)) begin
        irq_first = busy;
        if (clear_mid) begin
          s_write = 1'b1; s_writedata = 32'h4;
        end
      end
      @(posedge clk); #1;
      s_write = 1'b0; s_writedata = 32'd0;
    end
    s_read = 1'b0; s_cs_n = 1'b1;
    chk("busy_timeout", {31'd0, st[0]}, 32'd0);
  endtask

  task automatic run_len(input logic lvl, input int maxc, output int len, output int hi, output logic first);
    len = 0; hi = 0; first = ir_tx;
    while ((ir_env === lvl) && (len < maxc)) begin
      if (ir_tx === 1'b1) hi++;
      len++;
      @(negedge clk);
    end
  endtask

  // IR receive model / scoreboard monitor.
  initial begin : monitor
    exp_t        e;
    int          len, hi;
    logic        first;
    logic        ok;
    logic [31:0] word;
    @(negedge clk);
    forever begin
      while (ir_env !== 1'b1) @(negedge clk);
      if (!mon_en) begin
        while (ir_env === 1'b1) @(negedge clk);
        continue;
      end
      chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() == 0) begin
        while (ir_env === 1'b1) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      run_len(1'b1, 400, len, hi, first);
      chk("lead_mark_len", len, 160);
      chk("lead_tx_high", hi, 40);
      run_len(1'b0, 200, len, hi, first);
      chk("lead_space_len", len, 80);
      ok = 1'b1;
      word = 32'd0;
      for (int i = 0; i < 32; i++) begin
        run_len(1'b1, 50, len, hi, first);
        if ((len != 10) || (first !== 1'b1)) ok = 1'b0;
        run_len(1'b0, 50, len, hi, first);
        if (len == 30)      word[i] = 1'b1;
        else if (len != 10) ok = 1'b0;
      end
      run_len(1'b1, 50, len, hi, first);
      if ((len != 10) || (first !== 1'b1)) ok = 1'b0;
      chk("frame_timing", {31'd0, ok}, 32'd1);
      chk("frame_word", word, e.word);
      run_len(1'b0, 60, len, hi, first);
      if (e.b2b) chk("b2b_gap", len, 40);
      else       chk("idle_gap_min", {31'd0, len >= 40}, 32'd1);
    end
  end

  initial begin : watchdog
    #1000000;
    failures++;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] v;
    int busy, irqf;
    s_cs_n = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = 1'b0; s_writedata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_env", {31'd0, ir_env}, 32'd0);
    chk("rst_tx", {31'd0, ir_tx}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    read_reg(1'b1, v); chk("rst_status", v, 32'h0);
    idle(5);

    // All-zero word
    chk("t1_env_before", {31'd0, ir_env}, 32'd0);
    push_exp(32'h00000000, 1'b0);
    bus_write(1'b0, 32'h00000000);
    chk("t1_env_next", {31'd0, ir_env}, 32'd1);
    poll_busy(1, 1'b0, busy, irqf);
    chk("t1_busy", busy, 930);
    read_reg(1'b1, v); chk("t1_status_done", v, 32'h4);
    bus_write(1'b1, 32'h4);
    read_reg(1'b1, v); chk("t1_irq_clr", v, 32'h0);
    idle(100);

    // All-ones word
    push_exp(32'hFFFFFFFF, 1'b0);
    bus_write(1'b0, 32'hFFFFFFFF);
    read_reg(1'b0, v); chk("t2_data_read", v, 32'hFFFFFFFF);
    poll_busy(1, 1'b0, busy, irqf);
    chk("t2_busy", busy, 1570);
    read_reg(1'b1, v); chk("t2_status_done", v, 32'h4);
    bus_write(1'b1, 32'h4);
    idle(100);

    // Pending word follows with no idle cycle; irq at both ends
    push_exp(32'h12345678, 1'b1);
    push_exp(32'hA5A5A5A5, 1'b0);
    bus_write(1'b0, 32'h12345678);
    bus_write(1'b0, 32'hA5A5A5A5);
    read_reg(1'b1, v); chk("t3_status_pend", v, 32'h3);
    poll_busy(2, 1'b1, busy, irqf);
    chk("t3_irq_first", irqf, 1191);
    chk("t3_busy", busy, 2440);
    read_reg(1'b1, v); chk("t3_status_done", v, 32'h4);
    bus_write(1'b1, 32'h4);
    idle(100);

    // Third write while pending full is dropped
    push_exp(32'h00FF00FF, 1'b1);
    push_exp(32'h0000FFFF, 1'b0);
    bus_write(1'b0, 32'h00FF00FF);
    bus_write(1'b0, 32'h0000FFFF);
    bus_write(1'b0, 32'hDEADBEEF);
    read_reg(1'b1, v); chk("t4_status_ovr", v, 32'hB);
    bus_write(1'b1, 32'h8);
    read_reg(1'b1, v); chk("t4_ovr_clr", v, 32'h3);
    poll_busy(4, 1'b0, busy, irqf);
    chk("t4_busy", busy, 2500);
    read_reg(1'b1, v); chk("t4_status_done", v, 32'h4);
    bus_write(1'b1, 32'h4);
    idle(100);

    // Done coinciding with a DATA write, then with an irq-clear write
    push_exp(32'h00000000, 1'b1);
    push_exp(32'h0000000F, 1'b1);
    push_exp(32'h000000F0, 1'b0);
    bus_write(1'b0, 32'h00000000);
    bus_write(1'b0, 32'h0000000F);
    repeat (928) @(posedge clk);
    #1;
    bus_write(1'b0, 32'h000000F0);
    read_reg(1'b1, v); chk("t5_done_write", v, 32'h7);
    bus_write(1'b1, 32'h4);
    read_reg(1'b1, v); chk("t5_irq_clr", v, 32'h3);
    repeat (1008) @(posedge clk);
    #1;
    bus_write(1'b1, 32'h4);
    read_reg(1'b1, v); chk("t5_set_wins", v, 32'h5);
    poll_busy(1, 1'b0, busy, irqf);
    chk("t5_busy", busy, 1010);
    bus_write(1'b1, 32'h4);
    idle(100);

    // Loopback through the receive model
    push_exp(32'h40BF00FF, 1'b0);
    bus_write(1'b0, 32'h40BF00FF);
    poll_busy(1, 1'b0, busy, irqf);
    chk("t6_busy", busy, 1250);
    idle(100);

    // Reset in the middle of a frame
    mon_en = 1'b0;
    bus_write(1'b0, 32'h12345678);
    repeat (499) @(posedge clk);
    #1;
    chk("t7_pre_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t7_rst_env", {31'd0, ir_env}, 32'd0);
    chk("t7_rst_tx", {31'd0, ir_tx}, 32'd0);
    chk("t7_rst_irq", {31'd0, irq}, 32'd0);
    read_reg(1'b1, v); chk("t7_rst_status", v, 32'h0);
    reset = 1'b0;
    idle(20);
    chk("t7_stays_idle", {31'd0, ir_env}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
